// File: rtl/ram2_arbiter_if.sv
// Request/ack bundle between the fetch/MEM requesters and the RAM2 arbiter.
// Handshake: a request is a level held, with its address/data stable, until the matching ack;
// the ack is a one-cycle pulse and the returned data is valid in that cycle.
interface ram2_arbiter_if;
    logic        if_req_i;
    logic [15:0] if_addr_i;
    logic        if_ack_o;
    logic [15:0] if_data_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [15:0] mem_addr_i;
    logic [15:0] mem_wdata_i;
    logic        mem_ack_o;
    logic [15:0] mem_rdata_o;
    logic        stall_if_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output if_ack_o, if_data_o, mem_ack_o, mem_rdata_o, stall_if_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  if_ack_o, if_data_o, mem_ack_o, mem_rdata_o, stall_if_o
    );
endinterface

// File: rtl/ram2_arbiter.sv
// Grants the single RAM2 SRAM port to MEM or instruction fetch and sequences
// registered read and multi-cycle write pin timing.
module ram2_arbiter #(
    parameter int unsigned WR_PULSE = 1,
    parameter logic [1:0]  ADDR_HI  = 2'b00
) (
    input  logic          CLK,
    input  logic          RST,
    ram2_arbiter_if.slave bus,
    output logic [17:0]   Ram2Addr_o,
    inout  wire  [15:0]   Ram2Data_io,
    output logic          Ram2OE_o,
    output logic          Ram2WE_o,
    output logic          Ram2EN_o,
    output logic [2:0]    dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_IF    = 3'd1,
        S_RD_MEM   = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5
    } state_e;

    localparam logic [2:0] PULSE_LAST = 3'(WR_PULSE - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        en_n_q, oe_n_q, we_n_q, drive_q;
    logic        if_ack_q, mem_ack_q;
    logic [15:0] if_data_q, mem_rdata_q;
    logic        decide, mem_ok, if_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        decide  = (state_q == S_IDLE) || (state_q == S_RD_IF) ||
                  (state_q == S_RD_MEM) || (state_q == S_WR_HOLD);
        // The requester finishing at this edge still holds its old request until it sees the ack.
        mem_ok  = bus.mem_req_i && !((state_q == S_RD_MEM) || (state_q == S_WR_HOLD));
        if_ok   = bus.if_req_i && (state_q != S_RD_IF);
        if (decide) begin
            if (mem_ok) begin
                state_d = bus.mem_we_i ? S_WR_SETUP : S_RD_MEM;
                addr_d  = {ADDR_HI, bus.mem_addr_i};
                if (bus.mem_we_i) wdata_d = bus.mem_wdata_i;
            end else if (if_ok) begin
                state_d = S_RD_IF;
                addr_d  = {ADDR_HI, bus.if_addr_i};
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_WR_SETUP: begin
                    state_d = S_WR_PULSE;
                    cnt_d   = PULSE_LAST;
                end
                S_WR_PULSE: begin
                    if (cnt_q == 3'd0) state_d = S_WR_HOLD;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            en_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            // Pins are decoded from the next state so they change cleanly on the edge.
            en_n_q    <= (state_d == S_IDLE);
            oe_n_q    <= !((state_d == S_RD_IF) || (state_d == S_RD_MEM));
            we_n_q    <= (state_d != S_WR_PULSE);
            drive_q   <= (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                         (state_d == S_WR_HOLD);
            if_ack_q  <= (state_q == S_RD_IF);
            mem_ack_q <= (state_q == S_RD_MEM) || (state_q == S_WR_HOLD);
            if (state_q == S_RD_IF)  if_data_q   <= Ram2Data_io;
            if (state_q == S_RD_MEM) mem_rdata_q <= Ram2Data_io;
        end
    end

    assign Ram2Addr_o  = addr_q;
    assign Ram2Data_io = drive_q ? wdata_q : 16'bz;
    assign Ram2OE_o    = oe_n_q;
    assign Ram2WE_o    = we_n_q;
    assign Ram2EN_o    = en_n_q;
    assign dbg_state_o = state_q;

    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_ack_o   = mem_ack_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.stall_if_o  = (state_q == S_RD_MEM) || (state_q == S_WR_SETUP) ||
                             (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD) ||
                             (bus.mem_req_i && !mem_ack_q);
endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter: SRAM model, vector table, scoreboard and corner sequences.
module tb_ram2_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RST3 = 1'b1;
    always #5 CLK = ~CLK;

    ram2_arbiter_if bus ();
    ram2_arbiter_if bus3 ();

    wire  [15:0] ram2_data;
    logic [17:0] Ram2Addr_o;
    logic        Ram2OE_o, Ram2WE_o, Ram2EN_o;
    logic [2:0]  dbg_state;

    wire  [15:0] ram2_data3;
    logic [17:0] Ram2Addr3;
    logic        Ram2OE3, Ram2WE3, Ram2EN3;
    logic [2:0]  dbg_state3;

    ram2_arbiter #(.WR_PULSE(2), .ADDR_HI(2'b00)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave),
        .Ram2Addr_o(Ram2Addr_o), .Ram2Data_io(ram2_data),
        .Ram2OE_o(Ram2OE_o), .Ram2WE_o(Ram2WE_o), .Ram2EN_o(Ram2EN_o),
        .dbg_state_o(dbg_state)
    );

    ram2_arbiter #(.WR_PULSE(3), .ADDR_HI(2'b10)) dut3 (
        .CLK(CLK), .RST(RST3), .bus(bus3.slave),
        .Ram2Addr_o(Ram2Addr3), .Ram2Data_io(ram2_data3),
        .Ram2OE_o(Ram2OE3), .Ram2WE_o(Ram2WE3), .Ram2EN_o(Ram2EN3),
        .dbg_state_o(dbg_state3)
    );

    // SRAM model: unwritten locations return a fixed pattern of the address.
    logic [255:0] wr_flag;
    logic [15:0]  wr_val [0:255];

    function automatic logic [7:0] idx(input logic [15:0] a);
        return {a[15], a[6:0]};
    endfunction

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] peek(input logic [15:0] a);
        return wr_flag[idx(a)] ? wr_val[idx(a)] : init_val(a);
    endfunction

    assign ram2_data = (!Ram2OE_o && !Ram2EN_o) ? peek(Ram2Addr_o[15:0]) : 16'bz;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_flag <= '0;
        end else if (!Ram2EN_o && !Ram2WE_o) begin
            wr_flag[idx(Ram2Addr_o[15:0])] <= 1'b1;
            wr_val[idx(Ram2Addr_o[15:0])]  <= ram2_data;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_read(input string name, input logic [15:0] act);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0h with empty expected queue", name, act);
        end else begin
            chk(name, {16'h0, act}, {16'h0, exp_q.pop_front()});
        end
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        bit          perturb;
    } vec_t;

    vec_t vecs [8];

    // Called at a negedge; returns at the negedge after the ack cycle's following edge.
    task automatic run_txn(input vec_t v);
        int cyc, oe_lo, we_lo, bus_ok, addr_ok, stall_cnt;
        bit got;
        cyc = 0; oe_lo = 0; we_lo = 0; bus_ok = 0; addr_ok = 0; stall_cnt = 0; got = 0;
        if (v.is_mem) begin
            bus.mem_req_i = 1'b1; bus.mem_we_i = v.we;
            bus.mem_addr_i = v.addr; bus.mem_wdata_i = v.wdata;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = v.addr;
        end
        if (!(v.is_mem && v.we)) exp_q.push_back(v.exp);
        while (!got && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (!Ram2OE_o) oe_lo++;
            if (!Ram2WE_o) we_lo++;
            if (bus.stall_if_o) stall_cnt++;
            if (!Ram2EN_o && Ram2Addr_o == {2'b00, v.addr}) addr_ok++;
            if (!Ram2EN_o && v.we && ram2_data == v.wdata) bus_ok++;
            if (v.perturb && cyc == 2) begin
                bus.mem_addr_i = v.addr + 16'd1;
                bus.mem_wdata_i = ~v.wdata;
            end
            got = v.is_mem ? bus.mem_ack_o : bus.if_ack_o;
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
        chk("latency", cyc, (v.is_mem && v.we) ? 32'd5 : 32'd2);
        chk("stall_cycles", stall_cnt, v.is_mem ? cyc - 1 : 0);
        if (v.is_mem && v.we) begin
            chk("wr_we_low_cycles", we_lo, 32'd2);
            chk("wr_oe_low_cycles", oe_lo, 32'd0);
            chk("wr_bus_cycles", bus_ok, 32'd4);
            chk("wr_addr_cycles", addr_ok, 32'd4);
            chk("wr_sram_value", {16'h0, peek(v.addr)}, {16'h0, v.wdata});
        end else begin
            chk("rd_oe_low_cycles", oe_lo, 32'd1);
            chk("rd_addr_cycles", addr_ok, 32'd1);
            chk("rd_we_low_cycles", we_lo, 32'd0);
            check_read("rd_data", v.is_mem ? bus.mem_rdata_o : bus.if_data_o);
        end
        bus.mem_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        @(negedge CLK);
        chk("ack_one_cycle", {30'b0, bus.if_ack_o, bus.mem_ack_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks3;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.mem_req_i = 0; bus.mem_we_i = 0;
        bus.mem_addr_i = 0; bus.mem_wdata_i = 0;
        bus3.if_req_i = 0; bus3.if_addr_i = 0; bus3.mem_req_i = 0; bus3.mem_we_i = 0;
        bus3.mem_addr_i = 0; bus3.mem_wdata_i = 0;

        vecs[0] = '{0, 0, 16'h0010, 16'h0000, 16'hA5A5, 0};
        vecs[1] = '{1, 1, 16'h8000, 16'h1234, 16'h0000, 0};
        vecs[2] = '{1, 0, 16'h8000, 16'h0000, 16'h1234, 0};
        vecs[3] = '{0, 0, 16'h8000, 16'h0000, 16'h1234, 0};
        vecs[4] = '{1, 1, 16'h0040, 16'h5555, 16'h0000, 1};
        vecs[5] = '{1, 0, 16'h0041, 16'h0000, 16'h5A1B, 0};
        vecs[6] = '{0, 0, 16'h0040, 16'h0000, 16'h5555, 0};
        vecs[7] = '{1, 0, 16'h0020, 16'h0000, 16'h5A7A, 0};

        repeat (3) @(negedge CLK);
        RST = 0;
        RST3 = 0;
        @(negedge CLK);
        chk("rst_pins", {29'b0, Ram2OE_o, Ram2WE_o, Ram2EN_o}, 32'h7);
        chk("rst_addr", {14'b0, Ram2Addr_o}, 32'h0);
        chk("rst_acks", {30'b0, bus.if_ack_o, bus.mem_ack_o}, 32'h0);
        chk("rst_data", {bus.if_data_o, bus.mem_rdata_o}, 32'h0);
        chk("rst_state", {29'b0, dbg_state}, 32'h0);
        chk("rst_stall", {31'b0, bus.stall_if_o}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
            if (i == 4) chk("perturb_addr_untouched", {31'b0, wr_flag[idx(16'h0041)]}, 32'h0);
        end

        // Both requests at once: MEM first, IF immediately after.
        bus.if_req_i = 1; bus.if_addr_i = 16'h0010;
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 16'h0020;
        exp_q.push_back(16'h5A7A);
        exp_q.push_back(16'hA5A5);
        #1 chk("both_stall_comb", {31'b0, bus.stall_if_o}, 32'h1);
        @(negedge CLK);
        chk("both_rdmem_stall", {31'b0, bus.stall_if_o}, 32'h1);
        chk("both_rdmem_addr", {14'b0, Ram2Addr_o}, 32'h00020);
        chk("both_rdmem_oe", {31'b0, Ram2OE_o}, 32'h0);
        chk("both_rdmem_state", {29'b0, dbg_state}, 32'h2);
        @(negedge CLK);
        chk("both_mem_ack", {30'b0, bus.mem_ack_o, bus.if_ack_o}, 32'h2);
        check_read("both_mem_data", bus.mem_rdata_o);
        chk("both_rdif_addr", {14'b0, Ram2Addr_o}, 32'h00010);
        chk("both_rdif_oe", {31'b0, Ram2OE_o}, 32'h0);
        bus.mem_req_i = 0;
        @(negedge CLK);
        chk("both_if_ack", {30'b0, bus.mem_ack_o, bus.if_ack_o}, 32'h1);
        check_read("both_if_data", bus.if_data_o);
        bus.if_req_i = 0;
        @(negedge CLK);

        // Continuous fetch stream: one ack every other cycle, addresses in order.
        bus.if_req_i = 1; bus.if_addr_i = 16'h0000;
        exp_q.push_back(init_val(16'h0000));
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            chk("b2b_ack", {31'b0, bus.if_ack_o}, (k % 2 == 0) ? 32'h1 : 32'h0);
            if (k % 2 == 1) begin
                chk("b2b_addr", {14'b0, Ram2Addr_o}, 32'((k - 1) / 2));
                chk("b2b_oe", {31'b0, Ram2OE_o}, 32'h0);
            end
            if (bus.if_ack_o) begin
                check_read("b2b_data", bus.if_data_o);
                if (k < 8) begin
                    bus.if_addr_i = bus.if_addr_i + 16'd1;
                    exp_q.push_back(init_val(bus.if_addr_i));
                end else begin
                    bus.if_req_i = 0;
                end
            end
        end
        @(negedge CLK);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a 3-cycle write pulse.
        bus3.mem_req_i = 1; bus3.mem_we_i = 1;
        bus3.mem_addr_i = 16'h0123; bus3.mem_wdata_i = 16'hCAFE;
        repeat (3) @(negedge CLK);
        chk("rst3_we_low", {31'b0, Ram2WE3}, 32'h0);
        chk("rst3_addr_hi", {14'b0, Ram2Addr3}, 32'h20123);
        chk("rst3_bus", {16'b0, ram2_data3}, 32'hCAFE);
        #2 RST3 = 1;
        #1;
        chk("rst3_pins_async", {29'b0, Ram2OE3, Ram2WE3, Ram2EN3}, 32'h7);
        chk("rst3_addr_async", {14'b0, Ram2Addr3}, 32'h0);
        chk("rst3_state_async", {29'b0, dbg_state3}, 32'h0);
        bus3.mem_req_i = 0;
        acks3 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 1) RST3 = 0;
            if (bus3.mem_ack_o) acks3++;
        end
        chk("rst3_no_ack", acks3, 32'd0);
        chk("rst3_rdata", {16'b0, bus3.mem_rdata_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
